// File: rtl/sram_req_port_if.sv
// sram_req_port_if: request/response channel between a client and the SRAM request port
interface sram_req_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              busy;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, busy
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, busy
  );
endinterface

// File: rtl/sram_req_port.sv
// sram_req_port: single-port SRAM with valid/ready requests, byte masks, 3-deep response queue and zero-fill
module sram_req_port #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 128,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clock,
  input logic reset,
  sram_req_port_if.slave io
);
  localparam int NB = DATA_W / 8;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] q [3];
  logic [1:0] wr_ptr, rd_ptr, count;
  logic [ADDR_W:0] clr_cnt;
  logic inflight, rst_d, accept, push, pop;
  always_comb begin
    state_nxt     = (state == INIT && clr_cnt == (ADDR_W+1)'(DEPTH-1)) ? RUN : state;
    io.req_ready  = !reset && !rst_d && state == RUN && ({1'b0, count} + {2'b0, inflight}) < 3'd3;
    io.busy       = reset ? (CLEAR_ON_RESET != 0) : (state == INIT);
    io.resp_valid = !reset && count != 2'd0;
    io.resp_rdata = io.resp_valid ? q[rd_ptr] : '0;
    accept        = io.req_valid && io.req_ready;
    push          = inflight;
    pop           = io.resp_valid && io.resp_ready;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CLEAR_ON_RESET != 0 ? INIT : RUN;
      clr_cnt  <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      rst_d    <= 1'b1;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= state == INIT ? clr_cnt + 1'b1 : clr_cnt;
      inflight <= accept && !io.req_write;
      rst_d    <= 1'b0;
      count    <= count + {1'b0, push} - {1'b0, pop};
      if (push) begin
        q[wr_ptr] <= rd_q;
        wr_ptr    <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
    end
  end
  // Array has no reset so contents survive a reset when zero-fill is disabled
  always_ff @(posedge clock) begin
    if (!reset && state == INIT) mem[clr_cnt[ADDR_W-1:0]] <= '0;
    else if (accept && io.req_write)
      for (int b = 0; b < NB; b++)
        if (io.req_wmask[b]) mem[io.req_addr][8*b +: 8] <= io.req_wdata[8*b +: 8];
    if (accept && !io.req_write) rd_q <= mem[io.req_addr];
  end
endmodule

// File: tb/tb_sram_req_port.sv
// tb_sram_req_port: scoreboard bench for sram_req_port with zero-fill and preserve-on-reset instances
module tb_sram_req_port;
  logic clock = 1'b0;
  logic rst1 = 1'b1;
  logic rst0 = 1'b1;
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  typedef struct {logic [31:0] d; int due;} exp_t;
  exp_t sb[$];
  bit seen = 1'b0;
  sram_req_port_if #(.DATA_W(32), .ADDR_W(7)) io1();
  sram_req_port_if #(.DATA_W(32), .ADDR_W(7)) io0();
  sram_req_port #(.DATA_W(32), .DEPTH(128), .CLEAR_ON_RESET(1)) dut1 (.clock(clock), .reset(rst1), .io(io1));
  sram_req_port #(.DATA_W(32), .DEPTH(128), .CLEAR_ON_RESET(0)) dut0 (.clock(clock), .reset(rst0), .io(io0));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (io1.resp_valid) begin
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL resp_unexpected got %h required no response", io1.resp_rdata);
      end else begin
        if (io1.resp_rdata !== sb[0].d) begin
          nerr++;
          $display("FAIL resp_data got %h required %h", io1.resp_rdata, sb[0].d);
        end
        if (!seen && sb[0].due != 0) begin
          nchk++;
          if (cyc !== sb[0].due) begin
            nerr++;
            $display("FAIL resp_latency got cycle %0d required cycle %0d", cyc, sb[0].due);
          end
        end
        seen = 1'b1;
        if (io1.resp_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] e, input bit chk);
    io1.req_valid = 1'b1;
    io1.req_write = w;
    io1.req_addr  = a;
    io1.req_wdata = d;
    io1.req_wmask = m;
    for (int t = 0; t < 50 && !io1.req_ready; t++) tick();
    if (!io1.req_ready) begin
      nchk++;
      nerr++;
      $display("FAIL issue_timeout got ready=0 required ready=1 addr %0d", a);
    end else if (!w) sb.push_back('{e, chk ? cyc + 2 : 0});
    tick();
  endtask
  task automatic idle();
    io1.req_valid = 1'b0;
    io1.req_write = 1'b0;
  endtask
  task automatic test_reset();
    int nb = 0;
    int first = -1;
    #1;
    nchk++;
    if (io1.req_ready !== 1'b0 || io1.resp_valid !== 1'b0 || io1.resp_rdata !== 32'h0 || io1.busy !== 1'b1) begin
      nerr++;
      $display("FAIL reset_outputs got rdy=%b vld=%b rdata=%h busy=%b required 0 0 0 1",
               io1.req_ready, io1.resp_valid, io1.resp_rdata, io1.busy);
    end
    tick();
    tick();
    rst1 = 1'b0;
    #1;
    nchk++;
    if (io1.resp_valid !== 1'b0 || io1.resp_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL cycle0_resp got vld=%b rdata=%h required 0 0", io1.resp_valid, io1.resp_rdata);
    end
    for (int k = 0; k < 130; k++) begin
      if (io1.busy) nb++;
      if (io1.req_ready && first < 0) first = k;
      tick();
    end
    nchk++;
    if (nb !== 128) begin
      nerr++;
      $display("FAIL busy_cycles got %0d required 128", nb);
    end
    nchk++;
    if (first !== 128) begin
      nerr++;
      $display("FAIL first_ready got cycle %0d required 128", first);
    end
  endtask
  task automatic test_zero_fill();
    issue(1'b0, 7'd0, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b0, 7'd64, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b0, 7'd127, 32'h0, 4'h0, 32'h0, 1'b1);
    idle();
  endtask
  task automatic test_stream();
    int c0;
    for (int i = 0; i < 32; i++) issue(1'b1, 7'(i), 32'(i * 3), 4'hF, 32'h0, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 16; i++) issue(1'b0, 7'(i), 32'h0, 4'h0, 32'(i * 3), 1'b1);
    idle();
    nchk++;
    if (cyc - c0 !== 16) begin
      nerr++;
      $display("FAIL stream_cycles got %0d required 16", cyc - c0);
    end
  endtask
  task automatic test_masked_write();
    issue(1'b1, 7'd5, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
    issue(1'b1, 7'd5, 32'h11223344, 4'h5, 32'h0, 1'b0);
    issue(1'b0, 7'd5, 32'h0, 4'h0, 32'hAA22CC44, 1'b1);
    idle();
  endtask
  task automatic test_backpressure();
    int acc = 0;
    logic [31:0] r0;
    for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
    io1.resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      io1.req_valid = 1'b1;
      io1.req_write = 1'b0;
      io1.req_addr  = 7'(20 + acc);
      if (io1.req_ready) begin
        sb.push_back('{32'((20 + acc) * 3), 0});
        acc++;
      end
      tick();
    end
    nchk++;
    if (acc !== 3 || io1.req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp_accepts got %0d ready=%b required 3 ready=0", acc, io1.req_ready);
    end
    r0 = io1.resp_rdata;
    tick();
    tick();
    nchk++;
    if (io1.resp_rdata !== r0 || io1.resp_valid !== 1'b1) begin
      nerr++;
      $display("FAIL bp_stable got %h vld=%b required %h vld=1", io1.resp_rdata, io1.resp_valid, r0);
    end
    io1.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io1.req_addr = 7'(20 + acc);
      if (io1.req_ready) begin
        sb.push_back('{32'((20 + acc) * 3), 0});
        acc++;
      end
      tick();
    end
    idle();
    nchk++;
    if (acc <= 3) begin
      nerr++;
      $display("FAIL bp_resume got %0d accepts required more than 3", acc);
    end
  endtask
  task automatic test_read_after_write();
    issue(1'b1, 7'd127, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 7'd127, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1);
    idle();
  endtask
  task automatic test_reset_mid();
    io0.req_valid = 1'b0;
    io0.req_write = 1'b0;
    io0.req_addr = '0;
    io0.req_wdata = '0;
    io0.req_wmask = '0;
    io0.resp_ready = 1'b0;
    tick();
    rst0 = 1'b0;
    #1;
    nchk++;
    if (io0.req_ready !== 1'b0 || io0.busy !== 1'b0) begin
      nerr++;
      $display("FAIL nc_cycle0 got rdy=%b busy=%b required 0 0", io0.req_ready, io0.busy);
    end
    tick();
    nchk++;
    if (io0.req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL nc_cycle1_ready got %b required 1", io0.req_ready);
    end
    io0.req_valid = 1'b1;
    io0.req_write = 1'b1;
    io0.req_wmask = 4'hF;
    io0.req_addr = 7'd9;
    io0.req_wdata = 32'h12345678;
    tick();
    io0.req_addr = 7'd10;
    io0.req_wdata = 32'h0BADF00D;
    tick();
    io0.req_write = 1'b0;
    io0.req_addr = 7'd9;
    tick();
    io0.req_addr = 7'd10;
    tick();
    io0.req_valid = 1'b0;
    tick();
    tick();
    nchk++;
    if (io0.resp_valid !== 1'b1 || io0.resp_rdata !== 32'h12345678) begin
      nerr++;
      $display("FAIL nc_pending got vld=%b rdata=%h required 1 12345678", io0.resp_valid, io0.resp_rdata);
    end
    rst0 = 1'b1;
    #1;
    nchk++;
    if (io0.resp_valid !== 1'b0 || io0.req_ready !== 1'b0 || io0.resp_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL nc_in_reset got vld=%b rdy=%b rdata=%h required 0 0 0", io0.resp_valid, io0.req_ready, io0.resp_rdata);
    end
    tick();
    rst0 = 1'b0;
    io0.resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      nchk++;
      if (io0.resp_valid !== 1'b0 || io0.resp_rdata !== 32'h0) begin
        nerr++;
        $display("FAIL nc_stale cycle %0d got vld=%b rdata=%h required 0 0", k, io0.resp_valid, io0.resp_rdata);
      end
      tick();
    end
    io0.req_valid = 1'b1;
    io0.req_addr = 7'd9;
    tick();
    io0.req_addr = 7'd10;
    tick();
    io0.req_valid = 1'b0;
    nchk++;
    if (io0.resp_valid !== 1'b1 || io0.resp_rdata !== 32'h12345678) begin
      nerr++;
      $display("FAIL nc_preserved_9 got vld=%b rdata=%h required 1 12345678", io0.resp_valid, io0.resp_rdata);
    end
    tick();
    nchk++;
    if (io0.resp_valid !== 1'b1 || io0.resp_rdata !== 32'h0BADF00D) begin
      nerr++;
      $display("FAIL nc_preserved_10 got vld=%b rdata=%h required 1 0badf00d", io0.resp_valid, io0.resp_rdata);
    end
    tick();
    nchk++;
    if (io0.resp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL nc_drained got vld=%b required 0", io0.resp_valid);
    end
  endtask
  initial begin
    io1.req_valid = 1'b0;
    io1.req_write = 1'b0;
    io1.req_addr = '0;
    io1.req_wdata = '0;
    io1.req_wmask = '0;
    io1.resp_ready = 1'b1;
    test_reset();
    test_zero_fill();
    test_stream();
    test_masked_write();
    test_backpressure();
    test_read_after_write();
    for (int t = 0; t < 100 && sb.size() != 0; t++) tick();
    nchk++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", sb.size());
    end
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
